// File: rtl/fine_delay_interp_pkg.sv
// fine_delay_interp_pkg
// Shared defaults for the fine-delay stage: sample/phase/output/address
// widths and the controller state encoding. Imported by the interface, the
// phase LUT and the top module.
package fine_delay_interp_pkg;

  localparam int INPUT_WD_DEF  = 14;
  localparam int FRAC_WD_DEF   = 3;
  localparam int FD_OUT_WD_DEF = 24;
  localparam int ADDR_WD_DEF   = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fine_delay_interp_if.sv
// fine_delay_interp_if
// Bundles the control, LUT-load, sample-in and sample-out signals of the
// fine-delay stage.
//   master : drives tx_en, start, lut_*, fine_din*; observes fine_dout*, busy
//   slave  : the fine-delay stage itself
interface fine_delay_interp_if
  import fine_delay_interp_pkg::*;
#(
  parameter int INPUT_WD  = INPUT_WD_DEF,
  parameter int FRAC_WD   = FRAC_WD_DEF,
  parameter int FD_OUT_WD = FD_OUT_WD_DEF,
  parameter int ADDR_WD   = ADDR_WD_DEF
) ();

  logic                        tx_en;
  logic                        start;
  logic [ADDR_WD-1:0]          lut_addr;
  logic                        lut_wr_en;
  logic [FRAC_WD-1:0]          lut_wdata;
  logic signed [INPUT_WD-1:0]  fine_din;
  logic                        fine_din_valid;
  logic signed [FD_OUT_WD-1:0] fine_dout;
  logic                        fine_dout_valid;
  logic                        busy;

  modport master (
    output tx_en, start, lut_addr, lut_wr_en, lut_wdata, fine_din, fine_din_valid,
    input  fine_dout, fine_dout_valid, busy
  );

  modport slave (
    input  tx_en, start, lut_addr, lut_wr_en, lut_wdata, fine_din, fine_din_valid,
    output fine_dout, fine_dout_valid, busy
  );

endinterface

// File: rtl/fine_delay_interp_lut.sv
// fd_phase_lut
// Simple dual-port phase RAM: one write port, one read port with a
// registered output (1-cycle read latency). Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : fractional phase to store
//   rd_addr : read address
//   rd_data : registered read data
module fd_phase_lut
  import fine_delay_interp_pkg::*;
#(
  parameter int FRAC_WD = FRAC_WD_DEF,
  parameter int ADDR_WD = ADDR_WD_DEF
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_WD-1:0] wr_addr,
  input  logic [FRAC_WD-1:0] wr_data,
  input  logic [ADDR_WD-1:0] rd_addr,
  output logic [FRAC_WD-1:0] rd_data
);

  logic [FRAC_WD-1:0] mem [2**ADDR_WD];
  logic [FRAC_WD-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fine_delay_interp.sv
// fine_delay_interp
// Per-channel fractional-sample delay: y = x*(2^FRAC_WD - p) + xp*p where
// p = LUT[k] is the phase for the k-th accepted sample and xp the previous
// accepted sample. Three-cycle fixed latency, one sample per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fine_delay_interp_if.slave (control, LUT load, samples in/out)
module fine_delay_interp
  import fine_delay_interp_pkg::*;
#(
  parameter int INPUT_WD  = INPUT_WD_DEF,
  parameter int FRAC_WD   = FRAC_WD_DEF,
  parameter int FD_OUT_WD = FD_OUT_WD_DEF,
  parameter int ADDR_WD   = ADDR_WD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fine_delay_interp_if.slave   bus
);

  localparam int SUM_W = INPUT_WD + FRAC_WD + 1;
  localparam logic [ADDR_WD-1:0] K_LAST = {ADDR_WD{1'b1}};

  function automatic logic signed [FD_OUT_WD-1:0] sext_out(input logic signed [SUM_W-1:0] v);
    return FD_OUT_WD'(v);
  endfunction

  logic [1:0]                state_q, state_d;
  logic [ADDR_WD-1:0]        k_q, k_d;
  logic signed [INPUT_WD-1:0] xp_q, xp_d;
  logic                      active, hold, accept, lut_we;

  logic                      vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [INPUT_WD-1:0] x_p0_q, x_p0_d, xp_p0_q, xp_p0_d;
  logic [FRAC_WD-1:0]        p_p0;
  logic signed [SUM_W-1:0]   prod_a_p1_q, prod_a_p1_d, prod_b_p1_q, prod_b_p1_d;
  logic signed [SUM_W-1:0]   sum_p2_q, sum_p2_d;
  logic [FRAC_WD:0]          w_a;
  logic signed [SUM_W-1:0]   x_ext, xp_ext, wa_ext, wb_ext;

  // Pipeline contents survive only while the run continues; a falling start
  // or a rising tx_en empties every stage at the next edge.
  assign active = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign hold   = active && bus.start && !bus.tx_en;
  assign accept = (state_q == ST_RUN) && hold && bus.fine_din_valid;
  assign lut_we = bus.lut_wr_en && bus.tx_en &&
                  ((state_q == ST_IDLE) || (state_q == ST_LOAD));

  always_comb begin
    state_d = state_q;
    if (bus.tx_en) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = ST_RUN;
        ST_LOAD: state_d = ST_IDLE;
        ST_RUN: begin
          if (!bus.start) state_d = ST_IDLE;
          else if (accept && (k_q == K_LAST)) state_d = ST_DONE;
        end
        default: if (!bus.start) state_d = ST_IDLE;
      endcase
    end
  end

  // k and xp are held at zero outside a run so both start clean on entry.
  always_comb begin
    k_d  = k_q;
    xp_d = xp_q;
    if (!active) begin
      k_d  = '0;
      xp_d = '0;
    end else if (accept) begin
      xp_d = bus.fine_din;
      if (k_q != K_LAST) k_d = k_q + 1'b1;
    end
  end

  // Stage p0: sample pair captured, LUT read at k issued
  always_comb begin
    vld_p0_d = accept;
    x_p0_d   = accept ? bus.fine_din : '0;
    xp_p0_d  = accept ? xp_q : '0;
  end

  fd_phase_lut #(
    .FRAC_WD (FRAC_WD),
    .ADDR_WD (ADDR_WD)
  ) u_lut (
    .clk     (clk),
    .wr_en   (lut_we),
    .wr_addr (bus.lut_addr),
    .wr_data (bus.lut_wdata),
    .rd_addr (k_q),
    .rd_data (p_p0)
  );

  // Stage p1: both weighted products
  always_comb begin
    w_a         = {1'b1, {FRAC_WD{1'b0}}} - {1'b0, p_p0};
    x_ext       = SUM_W'(x_p0_q);
    xp_ext      = SUM_W'(xp_p0_q);
    wa_ext      = SUM_W'(w_a);
    wb_ext      = SUM_W'(p_p0);
    vld_p1_d    = hold && vld_p0_q;
    prod_a_p1_d = vld_p1_d ? (x_ext * wa_ext) : '0;
    prod_b_p1_d = vld_p1_d ? (xp_ext * wb_ext) : '0;
  end

  // Stage p2: sum
  always_comb begin
    vld_p2_d = hold && vld_p1_q;
    sum_p2_d = vld_p2_d ? (prod_a_p1_q + prod_b_p1_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      xp_q     <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      xp_q     <= xp_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    x_p0_q      <= x_p0_d;
    xp_p0_q     <= xp_p0_d;
    prod_a_p1_q <= prod_a_p1_d;
    prod_b_p1_q <= prod_b_p1_d;
    sum_p2_q    <= sum_p2_d;
  end

  assign bus.fine_dout_valid = vld_p2_q;
  assign bus.fine_dout       = vld_p2_q ? sext_out(sum_p2_q) : '0;
  assign bus.busy            = active;

endmodule

// File: tb/tb_fine_delay_interp.sv
module tb_fine_delay_interp;
  import fine_delay_interp_pkg::*;

  localparam int IW = 14;
  localparam int FW = 3;
  localparam int OW = 24;
  localparam int AW = 3;
  localparam int DEPTH = 2**AW;
  localparam int NPH = 2**FW;

  logic clk = 1'b0;
  logic rst;
  always #12 clk = ~clk;

  fine_delay_interp_if #(.INPUT_WD(IW), .FRAC_WD(FW), .FD_OUT_WD(OW), .ADDR_WD(AW)) bus ();

  fine_delay_interp #(.INPUT_WD(IW), .FRAC_WD(FW), .FD_OUT_WD(OW), .ADDR_WD(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int due; int y; } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;
  exp_t exp_q[$];
  int   out_log[$];

  // reference state: what the stage should hold, in plain arithmetic
  int m_lut [DEPTH];
  bit m_run;
  int m_cnt;
  int m_xp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int log_at(input int i);
    return (out_log.size() > i) ? out_log[i] : -999999;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_valid", int'(bus.fine_dout_valid), 1);
        chk("out_value", int'(bus.fine_dout), e.y);
        if (bus.fine_dout_valid) out_log.push_back(int'(bus.fine_dout));
      end else begin
        chk("no_valid", int'(bus.fine_dout_valid), 0);
        chk("zero_dout", int'(bus.fine_dout), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input bit v);
    int p;
    bus.fine_din       = IW'(x);
    bus.fine_din_valid = v;
    if (v && m_run && m_cnt < DEPTH) begin
      p = m_lut[m_cnt];
      exp_q.push_back('{cyc + 3, x * (NPH - p) + m_xp * p});
      m_xp = x;
      m_cnt++;
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.fine_din_valid = 1'b0;
    bus.fine_din       = IW'(1234);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic flush();
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc + 1)
      void'(exp_q.pop_back());
    m_run = 1'b0;
  endtask

  task automatic lut_wr(input int a, input int v);
    bus.tx_en     = 1'b1;
    bus.lut_wr_en = 1'b1;
    bus.lut_addr  = AW'(a);
    bus.lut_wdata = FW'(v);
    m_lut[a]      = v;
    step();
  endtask

  task automatic lut_end();
    bus.lut_wr_en = 1'b0;
    bus.tx_en     = 1'b0;
    step();
    step();
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    step();
    step();
    m_run = 1'b1;
    m_cnt = 0;
    m_xp  = 0;
    out_log.delete();
  endtask

  task automatic stop_run();
    bus.start = 1'b0;
    flush();
    step();
    chk("busy_after_stop", int'(bus.busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.tx_en = 1'b0;
    bus.start = 1'b0;
    bus.lut_addr = '0;
    bus.lut_wr_en = 1'b0;
    bus.lut_wdata = '0;
    bus.fine_din = '0;
    bus.fine_din_valid = 1'b0;
    m_run = 1'b0;
    m_cnt = 0;
    m_xp = 0;
    for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;

    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_dout", int'(bus.fine_dout), 0);
    chk("rst_valid", int'(bus.fine_dout_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    cmp_en = 1'b1;

    // sample offered in IDLE must vanish
    drive(55, 1'b1);
    idle(6);

    // all phases zero: pure gain of 8
    for (int a = 0; a < DEPTH; a++) lut_wr(a, 0);
    lut_end();
    start_run();
    drive(100, 1'b1);
    drive(-50, 1'b1);
    drive(7, 1'b1);
    idle(5);
    chk("gain_cnt", out_log.size(), 3);
    chk("gain_0", log_at(0), 800);
    chk("gain_1", log_at(1), -400);
    chk("gain_2", log_at(2), 56);
    chk("busy_in_run", int'(bus.busy), 1);
    stop_run();

    // two-tap interpolation
    lut_wr(0, 2);
    lut_wr(1, 4);
    lut_end();
    start_run();
    drive(20, 1'b1);
    drive(100, 1'b1);
    idle(5);
    chk("interp_0", log_at(0), 120);
    chk("interp_1", log_at(1), 480);
    stop_run();

    // full-scale extremes
    lut_wr(0, 0);
    lut_wr(1, 7);
    lut_wr(2, 1);
    lut_end();
    start_run();
    drive(8191, 1'b1);
    drive(-8192, 1'b1);
    drive(8191, 1'b1);
    idle(5);
    chk("ext_0", log_at(0), 65528);
    chk("ext_p7", log_at(1), 49145);
    chk("ext_p1", log_at(2), 49145);
    stop_run();

    // LUT[k]=k, valid gaps
    for (int a = 0; a < DEPTH; a++) lut_wr(a, a);
    lut_end();
    start_run();
    drive(10, 1'b1);
    drive(999, 1'b0);
    drive(-999, 1'b0);
    drive(20, 1'b1);
    drive(30, 1'b1);
    idle(5);
    chk("gap_cnt", out_log.size(), 3);
    chk("gap_0", log_at(0), 80);
    chk("gap_1", log_at(1), 150);
    chk("gap_2", log_at(2), 220);
    stop_run();

    // counter saturation: 10 offered, 8 accepted, then DONE
    start_run();
    for (int i = 1; i <= 10; i++) drive(i, 1'b1);
    idle(6);
    chk("sat_cnt", out_log.size(), 8);
    chk("sat_first", log_at(0), 8);
    chk("sat_last", log_at(7), 57);
    chk("busy_in_done", int'(bus.busy), 1);
    drive(77, 1'b1);
    idle(4);
    stop_run();

    // tx_en abort mid-run, with a write attempted in RUN
    start_run();
    drive(1, 1'b1);
    drive(2, 1'b1);
    drive(3, 1'b1);
    bus.tx_en = 1'b1;
    bus.start = 1'b0;
    bus.lut_wr_en = 1'b1;
    bus.lut_addr = '0;
    bus.lut_wdata = FW'(5);
    bus.fine_din_valid = 1'b1;
    flush();
    step();
    bus.lut_wr_en = 1'b0;
    step();
    chk("busy_in_load", int'(bus.busy), 0);
    bus.tx_en = 1'b0;
    idle(5);
    chk("abort_cnt", out_log.size(), 1);
    start_run();
    drive(10, 1'b1);
    idle(5);
    chk("lut_protect", log_at(0), 80);

    // reset during a run
    drive(4, 1'b1);
    drive(5, 1'b1);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.fine_din_valid = 1'b0;
    flush();
    step();
    rst = 1'b0;
    chk("rst_run_busy", int'(bus.busy), 0);
    chk("rst_run_valid", int'(bus.fine_dout_valid), 0);
    idle(5);

    chk("exp_drained", exp_q.size(), 0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
